memory_ctrl: RTL and testbench

Parametrised single-clock main memory for the CDEC CPU, replacing the fixed 256×8 store. Keeps the CPU port unchanged (combinational read, synchronous write) and adds a hardware clear sweep after reset or on request, a `ready` flag, and a second request/acknowledge port. The second port lets a loader or debug front end (DE0 switches/UART) read and write memory while the CPU runs, with the CPU taking priority on conflicts.

---
 rtl/memory_ctrl.sv | 151 +++++++++++++++
 tb/tb_memory_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_ctrl.sv
// Parametrised single-clock main memory with a CPU port and a debug request/ack port.
// Latency: CPU read combinational, writes on the next edge; debug ack/data one cycle after acceptance.
// Backpressure: a debug write stalls on a same-edge CPU write; no debug service while a clear sweep runs.
module memory_ctrl #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DEPTH       = 2**ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] adrs,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] q,
    input  logic                  wr_en,
    output logic                  ready,
    input  logic                  clear_req,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_adrs,
    input  logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_q
);

    localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1
    } state_t;

    logic [DATA_WIDTH-1:0] r_ram [DEPTH];
    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic                  r_ready;
    logic                  w_ready_nxt;
    logic                  r_dbg_ack;
    logic                  w_ack_nxt;
    logic [DATA_WIDTH-1:0] r_dbg_q;

    // Single shared write port: CPU and debug writes never land on the same edge.
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_wadr;
    logic [DATA_WIDTH-1:0] w_wdat;
    logic                  w_dbg_rd;
    logic                  w_dbg_acc;

    logic                  w_cpu_in;
    logic                  w_dbg_in;
    logic                  w_wr_in;
    logic [DATA_WIDTH-1:0] w_dbg_rdat;

    // Out-of-range addresses read as CLEAR_VALUE and are never written.
    assign w_cpu_in   = ({1'b0, adrs}     < LP_DEPTH);
    assign w_dbg_in   = ({1'b0, dbg_adrs} < LP_DEPTH);
    assign w_wr_in    = ({1'b0, w_wadr}   < LP_DEPTH);
    assign q          = w_cpu_in ? r_ram[adrs]     : CLEAR_VALUE;
    assign w_dbg_rdat = w_dbg_in ? r_ram[dbg_adrs] : CLEAR_VALUE;

    assign ready   = r_ready;
    assign dbg_ack = r_dbg_ack;
    assign dbg_q   = r_dbg_q;

    // State, sweep pointer and ready flag; reset restarts any sweep from address 0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Next state, write-port selection and debug acceptance.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_ready_nxt = r_ready;
        w_ack_nxt   = 1'b0;
        w_we        = 1'b0;
        w_wadr      = adrs;
        w_wdat      = data;
        w_dbg_rd    = 1'b0;
        // A debug op waits out the ack cycle and yields only writes to the CPU.
        w_dbg_acc   = dbg_req && !r_dbg_ack && !(dbg_we && wr_en);
        case (r_state)
            ST_CLEAR: begin
                w_we      = 1'b1;
                w_wadr    = r_ptr;
                w_wdat    = CLEAR_VALUE;
                w_ptr_nxt = r_ptr + ADDR_WIDTH'(1);
                if (r_ptr == LP_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_ready_nxt = 1'b1;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                    w_ready_nxt = 1'b0;
                end else begin
                    if (wr_en) begin
                        w_we = 1'b1;
                    end else if (w_dbg_acc && dbg_we) begin
                        w_we   = 1'b1;
                        w_wadr = dbg_adrs;
                        w_wdat = dbg_data;
                    end
                    if (w_dbg_acc) begin
                        w_ack_nxt = 1'b1;
                        w_dbg_rd  = !dbg_we;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_ptr_nxt   = '0;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // Memory array write; suppressed on reset edges.
    always_ff @(posedge clock) begin
        if (reset_n && w_we && w_wr_in) begin
            r_ram[w_wadr] <= w_wdat;
        end
    end

    // Debug completion pulse and read data (pre-edge contents, held between reads).
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_dbg_ack <= 1'b0;
            r_dbg_q   <= '0;
        end else begin
            r_dbg_ack <= w_ack_nxt;
            if (w_dbg_rd) begin
                r_dbg_q <= w_dbg_rdat;
            end
        end
    end

endmodule

// File: tb/tb_memory_ctrl.sv
// Self-checking bench for memory_ctrl: full-depth instance and a DEPTH=200 instance.
// Inputs are shared; each instance has its own reset.
module tb_memory_ctrl;

    logic       clock = 1'b0;
    logic       reset_n_a, reset_n_b;
    logic [7:0] adrs, data, dbg_adrs, dbg_data;
    logic       wr_en, clear_req, dbg_req, dbg_we;
    logic [7:0] q_a, dbg_q_a, q_b, dbg_q_b;
    logic       ready_a, dbg_ack_a, ready_b, dbg_ack_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    memory_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .CLEAR_VALUE(8'h00)) dut_a (
        .clock(clock), .reset_n(reset_n_a), .adrs(adrs), .data(data), .q(q_a),
        .wr_en(wr_en), .ready(ready_a), .clear_req(clear_req), .dbg_req(dbg_req),
        .dbg_we(dbg_we), .dbg_adrs(dbg_adrs), .dbg_data(dbg_data),
        .dbg_ack(dbg_ack_a), .dbg_q(dbg_q_a)
    );

    memory_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .CLEAR_VALUE(8'hA5)) dut_b (
        .clock(clock), .reset_n(reset_n_b), .adrs(adrs), .data(data), .q(q_b),
        .wr_en(wr_en), .ready(ready_b), .clear_req(clear_req), .dbg_req(dbg_req),
        .dbg_we(dbg_we), .dbg_adrs(dbg_adrs), .dbg_data(dbg_data),
        .dbg_ack(dbg_ack_b), .dbg_q(dbg_q_b)
    );

    typedef struct {
        logic       wr_en;
        logic [7:0] adrs;
        logic [7:0] data;
        logic       dbg_req;
        logic       dbg_we;
        logic [7:0] dbg_adrs;
        logic [7:0] dbg_data;
        logic [7:0] exp_q;
        logic       exp_ack;
        logic [7:0] exp_dbg_q;
    } vec_t;

    vec_t vecs[14];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; adrs = 8'h00; data = 8'h00; clear_req = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_adrs = 8'h00; dbg_data = 8'h00;
    endtask

    initial begin
        int bad;
        int acks;

        //             wr  adrs   data   req we  dadr   ddat   exp_q  ack exp_dbg_q
        vecs[0]  = '{1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 8'h5A, 1'b1, 8'h5A};
        vecs[2]  = '{1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 1'b0, 8'h5A};
        vecs[3]  = '{1'b1, 8'h20, 8'h11, 1'b1, 1'b1, 8'h21, 8'h22, 8'h11, 1'b0, 8'h5A};
        vecs[4]  = '{1'b0, 8'h21, 8'h00, 1'b1, 1'b1, 8'h21, 8'h22, 8'h22, 1'b1, 8'h5A};
        vecs[5]  = '{1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h11, 1'b0, 8'h5A};
        vecs[6]  = '{1'b1, 8'h30, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 8'h5A};
        vecs[7]  = '{1'b1, 8'h30, 8'h02, 1'b1, 1'b0, 8'h30, 8'h00, 8'h02, 1'b1, 8'h01};
        vecs[8]  = '{1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 8'h5A, 1'b0, 8'h01};
        vecs[9]  = '{1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 8'h5A, 1'b1, 8'h5A};
        vecs[10] = '{1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5A};
        vecs[11] = '{1'b0, 8'h40, 8'h00, 1'b1, 1'b1, 8'h40, 8'hC3, 8'hC3, 1'b1, 8'h5A};
        vecs[12] = '{1'b0, 8'h41, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5A};
        vecs[13] = '{1'b1, 8'h41, 8'h66, 1'b1, 1'b0, 8'h41, 8'h00, 8'h66, 1'b1, 8'h00};

        idle_inputs();
        reset_n_a = 1'b0;
        reset_n_b = 1'b0;

        // ---------------- full-depth instance: reset and initial sweep
        repeat (3) step();
        check("a_rst_ready", 32'(ready_a), 32'd0);
        check("a_rst_ack", 32'(dbg_ack_a), 32'd0);
        check("a_rst_dbg_q", 32'(dbg_q_a), 32'd0);
        reset_n_a = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            step();
            if (k == 255) check("a_ready_edge255", 32'(ready_a), 32'd0);
            if (k == 256) check("a_ready_edge256", 32'(ready_a), 32'd1);
        end
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            adrs = 8'(a);
            #1;
            if (q_a !== 8'h00) bad++;
        end
        check("a_cleared_words_nonzero", 32'(bad), 32'd0);

        // ---------------- vector table
        for (int i = 0; i < 14; i++) begin
            wr_en    = vecs[i].wr_en;
            adrs     = vecs[i].adrs;
            data     = vecs[i].data;
            dbg_req  = vecs[i].dbg_req;
            dbg_we   = vecs[i].dbg_we;
            dbg_adrs = vecs[i].dbg_adrs;
            dbg_data = vecs[i].dbg_data;
            step();
            check($sformatf("v%0d_q", i), 32'(q_a), 32'(vecs[i].exp_q));
            check($sformatf("v%0d_ack", i), 32'(dbg_ack_a), 32'(vecs[i].exp_ack));
            check($sformatf("v%0d_dbg_q", i), 32'(dbg_q_a), 32'(vecs[i].exp_dbg_q));
            check($sformatf("v%0d_ready", i), 32'(ready_a), 32'd1);
        end

        // ---------------- clear request with a pending debug read
        idle_inputs();
        clear_req = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_adrs = 8'h10;
        step();
        check("clr_ready_drop", 32'(ready_a), 32'd0);
        check("clr_ack_first", 32'(dbg_ack_a), 32'd0);
        clear_req = 1'b0;
        acks = 0;
        for (int k = 1; k <= 256; k++) begin
            // CPU write and a second clear request during the sweep must both be ignored
            wr_en     = (k == 10);
            adrs      = 8'h00;
            data      = 8'h99;
            clear_req = (k == 100);
            step();
            if (dbg_ack_a) acks++;
            if (k == 255) check("clr_ready_edge255", 32'(ready_a), 32'd0);
            if (k == 256) check("clr_ready_edge256", 32'(ready_a), 32'd1);
        end
        wr_en = 1'b0; clear_req = 1'b0;
        check("clr_acks_during_sweep", 32'(acks), 32'd0);
        step();
        check("clr_pending_ack", 32'(dbg_ack_a), 32'd1);
        check("clr_pending_dbg_q", 32'(dbg_q_a), 32'd0);
        dbg_req = 1'b0;
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            adrs = 8'(a);
            #1;
            if (q_a !== 8'h00) bad++;
        end
        check("clr_words_nonzero", 32'(bad), 32'd0);

        // ---------------- DEPTH=200 instance
        idle_inputs();
        step();
        reset_n_b = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (k == 199) check("b_ready_edge199", 32'(ready_b), 32'd0);
            if (k == 200) check("b_ready_edge200", 32'(ready_b), 32'd1);
        end
        wr_en = 1'b1; adrs = 8'hF0; data = 8'h77;
        step();
        wr_en = 1'b0;
        check("b_oor_cpu_q", 32'(q_b), 32'hA5);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_adrs = 8'hF0; dbg_data = 8'h77;
        step();
        check("b_oor_dbg_wr_ack", 32'(dbg_ack_b), 32'd1);
        dbg_req = 1'b0;
        step();
        wr_en = 1'b1; adrs = 8'h05; data = 8'h33;
        step();
        wr_en = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_adrs = 8'h05;
        step();
        check("b_rd05_ack", 32'(dbg_ack_b), 32'd1);
        check("b_rd05_dbg_q", 32'(dbg_q_b), 32'h33);
        dbg_req = 1'b0;
        step();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_adrs = 8'hF0;
        step();
        check("b_oor_rd_ack", 32'(dbg_ack_b), 32'd1);
        check("b_oor_rd_dbg_q", 32'(dbg_q_b), 32'hA5);
        dbg_req = 1'b0;
        adrs = 8'hC7; #1;
        check("b_q_last", 32'(q_b), 32'hA5);
        adrs = 8'hC8; #1;
        check("b_q_first_oor", 32'(q_b), 32'hA5);
        adrs = 8'h28; #1;
        check("b_q_alias28", 32'(q_b), 32'hA5);
        adrs = 8'h05; #1;
        check("b_q_05", 32'(q_b), 32'h33);

        // reset in the middle of a sweep, at pointer 100
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (100) step();
        check("b_mid_ready", 32'(ready_b), 32'd0);
        reset_n_b = 1'b0;
        step();
        check("b_rst_ready", 32'(ready_b), 32'd0);
        check("b_rst_ack", 32'(dbg_ack_b), 32'd0);
        check("b_rst_dbg_q", 32'(dbg_q_b), 32'd0);
        reset_n_b = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (k == 199) check("b_restart_edge199", 32'(ready_b), 32'd0);
            if (k == 200) check("b_restart_edge200", 32'(ready_b), 32'd1);
        end
        adrs = 8'h05; #1;
        check("b_q_05_cleared", 32'(q_b), 32'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
